// File: rtl/cpu_debug_pkg.sv
// Shared types and jdo field positions for the debug-RAM arbiter.
package cpu_debug_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_JTAG,
    RD_CPU
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD
  } jtag_op_t;

  localparam int JDO_ADDR_LSB  = 2;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_WDATA_MSB = 34;

endpackage

// File: rtl/cpu_debug_mem_arb_pick.sv
// Grant logic between the JTAG slot and the CPU port.
// CPU_DEBUG_MEM_ARB_RR_EN selects round-robin; otherwise JTAG has fixed priority.
module cpu_debug_mem_arb_pick (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic jtag_req,
  input  logic cpu_req,
  output logic grant_jtag,
  output logic grant_cpu
);

`ifdef CPU_DEBUG_MEM_ARB_RR_EN
  logic last_cpu;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cpu <= 1'b1;
    end else if (grant_jtag || grant_cpu) begin
      last_cpu <= grant_cpu;
    end
  end

  // The requester not served last wins a contended grant.
  always_comb begin
    grant_jtag = 1'b0;
    grant_cpu  = 1'b0;
    if (en) begin
      if (jtag_req && (last_cpu || !cpu_req)) begin
        grant_jtag = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
  end
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  always_comb begin
    grant_jtag = 1'b0;
    grant_cpu  = 1'b0;
    if (en) begin
      if (jtag_req) begin
        grant_jtag = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cpu_debug_mem_arbiter.sv
// Shares the single-ported OCI debug RAM between JTAG commands and the CPU monitor port.
// Build option: CPU_DEBUG_MEM_ARB_RR_EN enables round-robin arbitration.
module cpu_debug_mem_arbiter
  import cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int JDO_W  = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              jtag_addr_ld,
  input  logic              jtag_wr,
  input  logic              jtag_rd,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rdvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t            state, state_next;
  jtag_op_t          slot_op;
  logic [31:0]       slot_data;
  logic [ADDR_W-1:0] ptr;
  logic              slot_busy;
  logic              grant_jtag, grant_cpu;
  logic              jtag_done;
  logic              ld_acc, wr_acc, rd_acc, drop;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_ADDR_LSB-1:0], jdo[JDO_W-1:JDO_WDATA_MSB+1]};

  assign slot_busy = (slot_op != OP_NONE);

  // Only the highest-priority strobe can be taken, and only into an empty slot.
  assign ld_acc = jtag_addr_ld && !slot_busy;
  assign wr_acc = jtag_wr && !jtag_addr_ld && !slot_busy;
  assign rd_acc = jtag_rd && !jtag_addr_ld && !jtag_wr && !slot_busy;
  assign drop   = ((jtag_addr_ld || jtag_wr || jtag_rd) && slot_busy) ||
                  (jtag_addr_ld && jtag_wr) || (jtag_addr_ld && jtag_rd) ||
                  (jtag_wr && jtag_rd);

  cpu_debug_mem_arb_pick u_pick (
    .clk        (clk),
    .reset      (reset),
    .en         ((state == IDLE) && !reset),
    .jtag_req   (slot_busy),
    .cpu_req    (cpu_req),
    .grant_jtag (grant_jtag),
    .grant_cpu  (grant_cpu)
  );

  // NOTE: every output of this block gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    state_next      = state;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = ptr;
    ram_wdata       = slot_data;
    ram_be          = 4'hF;
    cpu_waitrequest = 1'b1;
    jtag_done       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_jtag) begin
          ram_en = 1'b1;
          if (slot_op == OP_WR) begin
            ram_we    = 1'b1;
            jtag_done = 1'b1;
          end else begin
            state_next = RD_JTAG;
          end
        end else if (grant_cpu) begin
          cpu_waitrequest = 1'b0;
          ram_en          = 1'b1;
          ram_we          = cpu_we;
          ram_addr        = cpu_addr;
          ram_wdata       = cpu_wdata;
          ram_be          = cpu_be;
          if (!cpu_we) state_next = RD_CPU;
        end
      end
      RD_JTAG: begin
        jtag_done  = 1'b1;
        state_next = IDLE;
      end
      RD_CPU:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cpu_rdata     = ram_rdata;
  assign cpu_rdvalid   = (state == RD_CPU) && !reset;
  assign monitor_ready = !slot_busy;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      slot_op       <= OP_NONE;
      slot_data     <= '0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
    end else begin
      state <= state_next;
      if (jtag_done) begin
        slot_op <= OP_NONE;
        ptr     <= ptr + ADDR_W'(1);
      end else if (wr_acc) begin
        slot_op   <= OP_WR;
        slot_data <= jdo[JDO_WDATA_LSB +: 32];
      end else if (rd_acc) begin
        slot_op <= OP_RD;
      end
      if (ld_acc) ptr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      if (state == RD_JTAG) MonDReg <= ram_rdata;
      // A drop in the same cycle as an accepted load still leaves the error set.
      if (drop) begin
        monitor_error <= 1'b1;
      end else if (ld_acc) begin
        monitor_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_debug_mem_arbiter.sv
// Self-checking bench for cpu_debug_mem_arbiter: vector table, corner sequences, random traffic vs. a memory model.
module tb_cpu_debug_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int JDO_W  = 38;
`ifdef CPU_DEBUG_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int K_LD = 0;
  localparam int K_WR = 1;
  localparam int K_RD = 2;

  logic              clk;
  logic              reset;
  logic [JDO_W-1:0]  jdo;
  logic              jtag_addr_ld, jtag_wr, jtag_rd;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_waitrequest;
  logic [31:0]       cpu_rdata;
  logic              cpu_rdvalid;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic [31:0]       ram_rdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;

  cpu_debug_mem_arbiter #(.ADDR_W(ADDR_W), .JDO_W(JDO_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .jdo             (jdo),
    .jtag_addr_ld    (jtag_addr_ld),
    .jtag_wr         (jtag_wr),
    .jtag_rd         (jtag_rd),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_be          (cpu_be),
    .cpu_waitrequest (cpu_waitrequest),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdvalid     (cpu_rdvalid),
    .ram_en          (ram_en),
    .ram_we          (ram_we),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_be          (ram_be),
    .ram_rdata       (ram_rdata),
    .MonDReg         (MonDReg),
    .monitor_ready   (monitor_ready),
    .monitor_error   (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Debug RAM with one-cycle read latency, plus an access log.
  logic [31:0]       mem     [256];
  logic [31:0]       ref_mem [256];
  logic [ADDR_W-1:0] last_addr;
  logic              last_we;
  logic [3:0]        last_be;
  int                wr_count;
  int                rdvalid_count;

  always @(posedge clk) begin
    if (ram_en) begin
      last_addr <= ram_addr;
      last_we   <= ram_we;
      last_be   <= ram_be;
      if (ram_we) begin
        wr_count <= wr_count + 1;
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
    if (cpu_rdvalid) rdvalid_count <= rdvalid_count + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives strobes for one cycle; returns one time unit after the accepting edge.
  task automatic jtag_strobe(input bit ld, input bit wr, input bit rd, input logic [31:0] arg);
    jdo = '0;
    if (ld) jdo[ADDR_W+1:2] = arg[ADDR_W-1:0];
    else    jdo[34:3]       = arg;
    jtag_addr_ld = ld;
    jtag_wr      = wr;
    jtag_rd      = rd;
    @(posedge clk);
    #1;
    jtag_addr_ld = 1'b0;
    jtag_wr      = 1'b0;
    jtag_rd      = 1'b0;
  endtask

  task automatic wait_ready(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (monitor_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
  endtask

  task automatic cpu_access(input bit we, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output bit ok, output bit valid,
                            output logic [31:0] rd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_be    = be;
    ok        = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (!cpu_waitrequest) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;
    valid   = 1'b0;
    rd      = '0;
    if (ok && !we) begin
      #1;
      valid = cpu_rdvalid;
      rd    = cpu_rdata;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int          kind;
    logic [31:0] arg;
    logic [7:0]  exp_addr;
    logic [31:0] exp_mon;
    int          exp_cyc;
  } jvec_t;

  jvec_t vec [15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          ok, valid, acc;
    int          cyc, w0, r0, bad, op;
    logic [31:0] rd, d;
    logic [7:0]  a, rptr;
    logic [3:0]  be;

    vec[0]  = '{K_LD, 32'h10,       8'h00, 32'h0,        0};
    vec[1]  = '{K_WR, 32'hDEADBEEF, 8'h10, 32'h0,        1};
    vec[2]  = '{K_LD, 32'h10,       8'h00, 32'h0,        0};
    vec[3]  = '{K_RD, 32'h0,        8'h10, 32'hDEADBEEF, 2};
    vec[4]  = '{K_WR, 32'h12345678, 8'h11, 32'h0,        1};
    vec[5]  = '{K_LD, 32'hFF,       8'h00, 32'h0,        0};
    vec[6]  = '{K_WR, 32'hA5A5A5A5, 8'hFF, 32'h0,        1};
    vec[7]  = '{K_WR, 32'h5A5A5A5A, 8'h00, 32'h0,        1};
    vec[8]  = '{K_WR, 32'h0BADF00D, 8'h01, 32'h0,        1};
    vec[9]  = '{K_LD, 32'hFF,       8'h00, 32'h0,        0};
    vec[10] = '{K_RD, 32'h0,        8'hFF, 32'hA5A5A5A5, 2};
    vec[11] = '{K_RD, 32'h0,        8'h00, 32'h5A5A5A5A, 2};
    vec[12] = '{K_RD, 32'h0,        8'h01, 32'h0BADF00D, 2};
    vec[13] = '{K_LD, 32'h11,       8'h00, 32'h0,        0};
    vec[14] = '{K_RD, 32'h0,        8'h11, 32'h12345678, 2};

    reset        = 1'b1;
    jdo          = '0;
    jtag_addr_ld = 1'b0;
    jtag_wr      = 1'b0;
    jtag_rd      = 1'b0;
    cpu_req      = 1'b1;
    cpu_we       = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    cpu_be       = 4'hF;
    tick(3);
    check("rst_ready",   32'(monitor_ready),   32'd1);
    check("rst_error",   32'(monitor_error),   32'd0);
    check("rst_mondreg", MonDReg,              32'd0);
    check("rst_rdvalid", 32'(cpu_rdvalid),     32'd0);
    check("rst_ram_en",  32'(ram_en),          32'd0);
    check("rst_ram_we",  32'(ram_we),          32'd0);
    check("rst_wait",    32'(cpu_waitrequest), 32'd1);
    cpu_req = 1'b0;
    reset   = 1'b0;

    // Table-driven JTAG command sequence.
    for (int i = 0; i < 15; i++) begin
      jtag_strobe(vec[i].kind == K_LD, vec[i].kind == K_WR, vec[i].kind == K_RD, vec[i].arg);
      if (vec[i].kind == K_LD) begin
        check($sformatf("vec%0d_ld_ready", i), 32'(monitor_ready), 32'd1);
        check($sformatf("vec%0d_ld_err", i),   32'(monitor_error), 32'd0);
      end else begin
        check($sformatf("vec%0d_busy", i), 32'(monitor_ready), 32'd0);
        wait_ready(ok, cyc);
        check($sformatf("vec%0d_done", i), 32'(ok),        32'd1);
        check($sformatf("vec%0d_lat", i),  cyc,            vec[i].exp_cyc);
        check($sformatf("vec%0d_addr", i), 32'(last_addr), 32'(vec[i].exp_addr));
        check($sformatf("vec%0d_be", i),   32'(last_be),   32'hF);
        check($sformatf("vec%0d_we", i),   32'(last_we),   32'(vec[i].kind == K_WR));
        if (vec[i].kind == K_WR)
          check($sformatf("vec%0d_mem", i), mem[vec[i].exp_addr], vec[i].arg);
        else
          check($sformatf("vec%0d_mon", i), MonDReg, vec[i].exp_mon);
      end
    end

    // Overrun: write strobe while a read occupies the slot.
    cpu_access(1'b1, 8'h50, 32'h5050A0A0, 4'hF, ok, valid, rd);
    check("ovr_setup", 32'(ok), 32'd1);
    jtag_strobe(1'b1, 1'b0, 1'b0, 32'h50);
    jtag_strobe(1'b0, 1'b0, 1'b1, 32'h0);
    w0 = wr_count;
    jtag_strobe(1'b0, 1'b1, 1'b0, 32'h99);
    check("ovr_err_set", 32'(monitor_error), 32'd1);
    wait_ready(ok, cyc);
    check("ovr_done",     32'(ok),  32'd1);
    check("ovr_no_write", wr_count, w0);
    check("ovr_mon",      MonDReg,  32'h5050A0A0);
    tick(3);
    check("ovr_sticky", 32'(monitor_error), 32'd1);
    jtag_strobe(1'b1, 1'b0, 1'b0, 32'h60);
    check("ovr_clear", 32'(monitor_error), 32'd0);

    // Simultaneous strobes: addr_ld beats wr, wr beats rd.
    w0 = wr_count;
    jtag_strobe(1'b1, 1'b1, 1'b0, 32'h70);
    check("multi_err",   32'(monitor_error), 32'd1);
    check("multi_ready", 32'(monitor_ready), 32'd1);
    tick(2);
    check("multi_no_write", wr_count, w0);
    jtag_strobe(1'b0, 1'b1, 1'b0, 32'h77777777);
    wait_ready(ok, cyc);
    check("multi_ptr", 32'(last_addr), 32'h70);
    jtag_strobe(1'b1, 1'b0, 1'b0, 32'h70);
    check("multi_clear", 32'(monitor_error), 32'd0);
    jtag_strobe(1'b0, 1'b1, 1'b1, 32'h88888888);
    check("wrrd_err", 32'(monitor_error), 32'd1);
    wait_ready(ok, cyc);
    check("wrrd_we",  32'(last_we), 32'd1);
    check("wrrd_mem", mem[8'h70],   32'h88888888);
    jtag_strobe(1'b1, 1'b0, 1'b0, 32'h30);

    // Contention: CPU read arrives while a JTAG write is pending (last grant = CPU).
    cpu_access(1'b1, 8'h20, 32'hC0FFEE00, 4'hF, ok, valid, rd);
    check("cont_setup", 32'(ok), 32'd1);
    jtag_strobe(1'b0, 1'b1, 1'b0, 32'hAAAA0030);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h20;
    cpu_be   = 4'hF;
    #1;
    check("cont_wait1",    32'(cpu_waitrequest), 32'd1);
    check("cont_jtag_adr", 32'(ram_addr),        32'h30);
    check("cont_jtag_we",  32'(ram_we),          32'd1);
    @(posedge clk);
    #2;
    check("cont_wait2",   32'(cpu_waitrequest), 32'd0);
    check("cont_cpu_adr", 32'(ram_addr),        32'h20);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    #1;
    check("cont_rdvalid", 32'(cpu_rdvalid), 32'd1);
    check("cont_rdata",   cpu_rdata,        32'hC0FFEE00);
    @(posedge clk);
    #2;
    check("cont_rdvalid_end", 32'(cpu_rdvalid), 32'd0);
    @(posedge clk);
    #1;

    // Contention after a JTAG grant: round-robin serves the CPU first.
    jtag_strobe(1'b1, 1'b0, 1'b0, 32'h40);
    jtag_strobe(1'b0, 1'b1, 1'b0, 32'hBBBB0040);
    tick(1);
    check("rr_ready", 32'(monitor_ready), 32'd1);
    jtag_strobe(1'b0, 1'b1, 1'b0, 32'hBBBB0041);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 8'h21;
    cpu_wdata = 32'hCCCC0021;
    cpu_be    = 4'hF;
    #1;
    acc = !cpu_waitrequest;
    check("rr_cpu_first", 32'(acc),      32'(RR));
    check("rr_addr",      32'(ram_addr), RR ? 32'h21 : 32'h41);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4 && !acc; i++) begin
      #1;
      if (!cpu_waitrequest) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;
    check("rr_cpu_acc", 32'(acc), 32'd1);
    wait_ready(ok, cyc);
    check("rr_done",     32'(ok),    32'd1);
    check("rr_jtag_mem", mem[8'h41], 32'hBBBB0041);
    check("rr_cpu_mem",  mem[8'h21], 32'hCCCC0021);

    // Reset during RD_JTAG abandons the read and clears the pointer.
    jtag_strobe(1'b1, 1'b0, 1'b0, 32'h10);
    jtag_strobe(1'b0, 1'b0, 1'b1, 32'h0);
    tick(1);
    r0    = rdvalid_count;
    reset = 1'b1;
    tick(1);
    check("rstrd_mon",     MonDReg,               32'd0);
    check("rstrd_ready",   32'(monitor_ready),    32'd1);
    check("rstrd_rdvalid", rdvalid_count,         r0);
    reset = 1'b0;
    jtag_strobe(1'b0, 1'b1, 1'b0, 32'h11112222);
    wait_ready(ok, cyc);
    check("rstrd_ptr", 32'(last_addr), 32'h0);

    // Reset during RD_CPU suppresses the rdvalid pulse.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h05;
    #1;
    check("rstcpu_acc", 32'(cpu_waitrequest), 32'd0);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    reset   = 1'b1;
    r0      = rdvalid_count;
    #1;
    check("rstcpu_rdvalid", 32'(cpu_rdvalid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rstcpu_count", rdvalid_count, r0);

    // Random sequential traffic against an array model.
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    rptr = 8'($urandom);
    jtag_strobe(1'b1, 1'b0, 1'b0, {24'h0, rptr});
    repeat (150) begin
      op = $urandom_range(0, 4);
      a  = 8'($urandom);
      d  = $urandom;
      be = 4'($urandom);
      case (op)
        0: begin
          jtag_strobe(1'b1, 1'b0, 1'b0, {24'h0, a});
          rptr = a;
        end
        1: begin
          jtag_strobe(1'b0, 1'b1, 1'b0, d);
          wait_ready(ok, cyc);
          check("rnd_jwr_done", 32'(ok), 32'd1);
          ref_mem[rptr] = d;
          rptr++;
        end
        2: begin
          jtag_strobe(1'b0, 1'b0, 1'b1, 32'h0);
          wait_ready(ok, cyc);
          check("rnd_jrd_done", 32'(ok), 32'd1);
          check("rnd_jrd_data", MonDReg, ref_mem[rptr]);
          rptr++;
        end
        3: begin
          cpu_access(1'b1, a, d, be, ok, valid, rd);
          check("rnd_cwr_acc", 32'(ok), 32'd1);
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        default: begin
          cpu_access(1'b0, a, d, be, ok, valid, rd);
          check("rnd_crd_acc",   32'(ok),    32'd1);
          check("rnd_crd_valid", 32'(valid), 32'd1);
          check("rnd_crd_data",  rd,         ref_mem[a]);
        end
      endcase
    end
    tick(2);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    check("mem_sweep", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_debug_mem_arbiter.md
Name: cpu_debug_mem_arbiter

Overview:
- Sits in the sysclk domain between the JTAG debug module's action strobes and the on-chip debug RAM (OCI memory), which is single-ported.
- Shares that RAM between two requesters:
  - the JTAG host, which issues address-load / write / read commands with auto-increment;
  - the CPU debug-monitor port, an Avalon-MM-style slave.
- Captures JTAG read data into MonDReg and drives monitor_ready / monitor_error back to the debug module.

Parameters:
- ADDR_W, 8, word-address width of the debug RAM (2^ADDR_W 32-bit words).
- JDO_W, 38, width of the jdo command bus.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  JDO_W  JTAG command payload: address = jdo[ADDR_W+1:2]; write data = jdo[34:3].
- jtag_addr_ld  in  1  pulse: load JTAG address pointer.
- jtag_wr  in  1  pulse: write jdo data at pointer, then pointer+1.
- jtag_rd  in  1  pulse: read pointer into MonDReg, then pointer+1.
- cpu_req  in  1  CPU access request, held until accepted.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  32  CPU write data.
- cpu_be  in  4  CPU byte enables.
- cpu_waitrequest  out  1  high = CPU request not accepted this cycle.
- cpu_rdata  out  32  read data; combinational pass-through of ram_rdata.
- cpu_rdvalid  out  1  read-data-valid pulse.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_be  out  4  RAM byte enables (4'hF for JTAG accesses).
- ram_rdata  in  32  RAM read data, 1-cycle latency.
- MonDReg  out  32  JTAG read-data capture register.
- monitor_ready  out  1  high = no JTAG command outstanding.
- monitor_error  out  1  sticky: JTAG command overrun.

Behaviour:
Reset values:
- IDLE state; pointer = 0; JTAG slot empty; MonDReg = 0.
- monitor_ready = 1, monitor_error = 0, cpu_rdvalid = 0.
- ram_en = ram_we = 0, cpu_waitrequest = 1.
- Reset mid-read abandons the read: no MonDReg update, no cpu_rdvalid pulse.

JTAG slot (one entry):
- Accepting jtag_wr or jtag_rd while the slot is empty occupies the slot, latches op and data, and drops monitor_ready on the next cycle.
- jtag_addr_ld with the slot empty loads the pointer immediately and clears monitor_error. It does not occupy the slot.
- Any strobe arriving while the slot is occupied is dropped and sets monitor_error, which stays set until the next accepted jtag_addr_ld.
- Several strobes in the same cycle: priority addr_ld > wr > rd. The lower-priority strobes are dropped and monitor_error is set.

FSM states: IDLE, RD_JTAG, RD_CPU.
- IDLE: the arbiter picks one candidate from {JTAG slot occupied, cpu_req}.
  - JTAG write: ram_en = ram_we = 1 this cycle; slot clears; pointer increments; monitor_ready = 1 next cycle; stay IDLE.
  - JTAG read: ram_en = 1 this cycle; go to RD_JTAG.
  - CPU grant: cpu_waitrequest = 0 combinationally this cycle and RAM signals are driven from the cpu_* inputs. A write stays IDLE; a read goes to RD_CPU.
- RD_JTAG: MonDReg <= ram_rdata; slot clears; pointer increments; monitor_ready = 1 next cycle; return to IDLE.
- RD_CPU: cpu_rdvalid = 1 for this cycle only, with cpu_rdata valid; return to IDLE.
- In both RD states: no grant is made, ram_en = 0, cpu_waitrequest = 1.

Throughput and arithmetic:
- Writes: 1 access/cycle. Reads: 1 access per 2 cycles.
- The pointer wraps modulo 2^ADDR_W (all-ones + 1 = 0).
- A jtag_addr_ld in the same cycle a JTAG access completes is not possible (the slot is occupied, so it is dropped with error).

Arbitration default: fixed priority, JTAG over CPU.

Optional Feature:
- Macro: CPU_DEBUG_MEM_ARB_RR_EN.
- Defined: round-robin between JTAG and CPU. A last-grant flag (reset value = CPU) gives priority to the requester not granted last. This guarantees the CPU is accepted within 2 grants under continuous JTAG traffic.
- Undefined: fixed JTAG priority; the CPU can starve.

Decomposition:
- Shared package cpu_debug_pkg holds:
  - FSM state enum {IDLE, RD_JTAG, RD_CPU};
  - JTAG op enum {OP_NONE, OP_WR, OP_RD};
  - jdo field-position constants (address LSB = 2, write data [34:3]).
- One natural sub-module, cpu_debug_mem_arb_pick: pure grant logic, including the RR flag under the macro. Everything else stays flat.

Test Plan:
- addr_ld with jdo address 8'h10, then jtag_wr data 32'hDEADBEEF, then jtag_rd after addr_ld 8'h10 -> RAM word 0x10 = DEADBEEF; MonDReg = DEADBEEF two cycles after rd accepted; pointer = 0x11; monitor_ready returns to 1.
- addr_ld 8'hFF, then two writes -> words 0xFF and 0x00 written; pointer wraps to 0x01.
- jtag_rd, then jtag_wr the next cycle while the slot is occupied -> wr dropped, monitor_error = 1; stays 1 until the next addr_ld, then 0.
- cpu_req read of addr 0x20 in the same cycle as a JTAG slot write -> fixed mode: JTAG granted first, cpu_waitrequest = 1 one cycle, CPU accepted next cycle, cpu_rdvalid one cycle after acceptance. RR mode (flag = CPU): JTAG granted first; under sustained JTAG traffic the CPU wins the next contended grant.
- reset asserted during RD_JTAG -> MonDReg = 0, monitor_ready = 1, no cpu_rdvalid, pointer = 0.
